// File: rtl/leaf_switch_pkg.sv
// Shared constants and header helpers for the leaf switch.
package leaf_switch_pkg;

    localparam int HDR_W     = 6;
    // Field positions inside the 6-bit header slice.
    localparam int GROUP_MSB = 5;
    localparam int GROUP_LSB = 2;
    localparam int LEAF_MSB  = 1;
    localparam int LEAF_LSB  = 0;

    localparam logic [HDR_W-1:0] NULL_HDR = 6'b000000;

    localparam int NUM_LOCAL = 4;
    localparam int UP_IDX    = 4;
    localparam int NUM_IN    = 5;

    function automatic logic [3:0] group_of(input logic [HDR_W-1:0] hdr);
        return hdr[GROUP_MSB:GROUP_LSB];
    endfunction

    function automatic logic [1:0] leaf_of(input logic [HDR_W-1:0] hdr);
        return hdr[LEAF_MSB:LEAF_LSB];
    endfunction

    function automatic logic hdr_is_null(input logic [HDR_W-1:0] hdr);
        return hdr == NULL_HDR;
    endfunction

endpackage

// File: rtl/leaf_switch_rr_arbiter.sv
// Five-requester round-robin arbiter; pointer follows the last transfer.
module rr_arbiter
    import leaf_switch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] req,
    output logic [NUM_IN-1:0] grant
);

    logic [2:0] ptr_r;
    logic [2:0] gidx_s;
    logic       found_s;

    // Pick the first requester after the pointer, wrapping around.
    always_comb begin
        grant   = '0;
        gidx_s  = 3'd0;
        found_s = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            int idx;
            idx = (int'(ptr_r) + k) % NUM_IN;
            if (!found_s && req[idx]) begin
                grant[idx] = 1'b1;
                gidx_s     = 3'(idx);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Requests are pre-qualified, so any grant is a transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= 3'd4;
        end else if (found_s) begin
            ptr_r <= gidx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/leaf_switch.sv
// Leaf switch: four local NIs plus one uplink, per-input FIFOs,
// header routing and round-robin arbitration on every output.
module leaf_switch
    import leaf_switch_pkg::*;
#(
    parameter logic [3:0] GROUP_ID  = 4'd5,
    parameter int         DATA_W    = 16,
    parameter int         BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DATA_W-1:0]   local_data_in,
    input  logic [3:0]            local_valid_in,
    output logic [3:0]            local_ready_out,
    output logic [4*DATA_W-1:0]   local_data_out,
    output logic [3:0]            local_valid_out,
    input  logic [DATA_W-1:0]     up_data_in,
    input  logic                  up_valid_in,
    output logic                  up_ready_out,
    output logic [DATA_W-1:0]     up_data_out,
    output logic                  up_valid_out,
    input  logic                  up_ready_in,
    output logic [7:0]            drop_count
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL      = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] CNT_READY_MAX = CW'(BUF_DEPTH - 2);

    function automatic logic [HDR_W-1:0] hdr_of(input logic [DATA_W-1:0] d);
        return d[DATA_W-1 -: HDR_W];
    endfunction

    logic [DATA_W-1:0] mem_r      [NUM_IN][BUF_DEPTH];
    logic [AW-1:0]     wr_ptr_r   [NUM_IN];
    logic [AW-1:0]     rd_ptr_r   [NUM_IN];
    logic [CW-1:0]     count_r    [NUM_IN];
    logic [DATA_W-1:0] in_data_s  [NUM_IN];
    logic [DATA_W-1:0] head_s     [NUM_IN];
    logic [2:0]        dest_s     [NUM_IN];
    logic [NUM_IN-1:0] req_s      [NUM_IN];
    logic [NUM_IN-1:0] grant_s    [NUM_IN];
    logic [DATA_W-1:0] out_data_s [NUM_IN];
    logic [NUM_IN-1:0] in_valid_s;
    logic [NUM_IN-1:0] bad_s;
    logic [NUM_IN-1:0] wr_s;
    logic [NUM_IN-1:0] drop_s;
    logic [NUM_IN-1:0] pop_s;
    logic [8:0]        drop_sum_s;
    logic              up_free_s;

    for (genvar g = 0; g < NUM_LOCAL; g++) begin : g_local_in
        assign in_data_s[g]       = local_data_in[g*DATA_W +: DATA_W];
        assign in_valid_s[g]      = local_valid_in[g];
        assign local_ready_out[g] = (count_r[g] <= CNT_READY_MAX);
    end
    assign in_data_s[UP_IDX]  = up_data_in;
    assign in_valid_s[UP_IDX] = up_valid_in;
    assign up_ready_out       = (count_r[UP_IDX] <= CNT_READY_MAX);

    // Classify arriving flits (store or drop) and route each FIFO head.
    always_comb begin
        drop_sum_s = {1'b0, drop_count};
        for (int i = 0; i < NUM_IN; i++) begin
            bad_s[i]  = hdr_is_null(hdr_of(in_data_s[i])) ||
                        ((i == UP_IDX) && (group_of(hdr_of(in_data_s[i])) != GROUP_ID));
            wr_s[i]   = in_valid_s[i] && !bad_s[i] && (count_r[i] != CNT_FULL);
            drop_s[i] = in_valid_s[i] && (bad_s[i] || (count_r[i] == CNT_FULL));
            head_s[i] = mem_r[i][rd_ptr_r[i]];
            dest_s[i] = (group_of(hdr_of(head_s[i])) == GROUP_ID) ?
                        {1'b0, leaf_of(hdr_of(head_s[i]))} : 3'(UP_IDX);
            drop_sum_s = drop_sum_s + 9'(drop_s[i]);
        end
    end

    // Build per-output requests; the uplink only accepts when its register frees.
    always_comb begin
        up_free_s = !up_valid_out || up_ready_in;
        for (int o = 0; o < NUM_IN; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                req_s[o][i] = (count_r[i] != '0) && (dest_s[i] == 3'(o)) &&
                              ((o != UP_IDX) || (up_free_s && (i != UP_IDX)));
            end
        end
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_arb
        rr_arbiter u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req_s[g]),
            .grant (grant_s[g])
        );
    end

    // Fold grants into FIFO pops and per-output data selection.
    always_comb begin
        pop_s = '0;
        for (int o = 0; o < NUM_IN; o++) begin
            out_data_s[o] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                pop_s[i]      = pop_s[i] | grant_s[o][i];
                out_data_s[o] = out_data_s[o] | (head_s[i] & {DATA_W{grant_s[o][i]}});
            end
        end
    end

    // FIFO storage array; contents need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (wr_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
                if (pop_s[i]) rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
                case ({wr_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CW'(1);
                    2'b01:   count_r[i] <= count_r[i] - CW'(1);
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Output registers and the saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            local_valid_out <= 4'd0;
            local_data_out  <= '0;
            up_valid_out    <= 1'b0;
            up_data_out     <= '0;
            drop_count      <= 8'd0;
        end else begin
            for (int o = 0; o < NUM_LOCAL; o++) begin
                local_valid_out[o] <= |grant_s[o];
                if (|grant_s[o]) begin
                    local_data_out[o*DATA_W +: DATA_W] <= out_data_s[o];
                end
            end
            if (|grant_s[UP_IDX]) begin
                up_valid_out <= 1'b1;
                up_data_out  <= out_data_s[UP_IDX];
            end else if (up_ready_in) begin
                up_valid_out <= 1'b0;
            end
            drop_count <= (drop_sum_s > 9'd255) ? 8'd255 : drop_sum_s[7:0];
        end
    end

endmodule

// File: tb/tb_leaf_switch.sv
// Scoreboard bench for leaf_switch (GROUP_ID 5, 16-bit flits, depth 4).
module tb_leaf_switch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] local_data_in = '0;
    logic [3:0]  local_valid_in = '0;
    logic [3:0]  local_ready_out;
    logic [63:0] local_data_out;
    logic [3:0]  local_valid_out;
    logic [15:0] up_data_in = '0;
    logic        up_valid_in = 1'b0;
    logic        up_ready_out;
    logic [15:0] up_data_out;
    logic        up_valid_out;
    logic        up_ready_in = 1'b1;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;
    int exp_drops = 0;
    logic [15:0] exp_q [5][$];

    always #5 clk = ~clk;

    leaf_switch #(.GROUP_ID(4'd5), .DATA_W(16), .BUF_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .local_data_in   (local_data_in),
        .local_valid_in  (local_valid_in),
        .local_ready_out (local_ready_out),
        .local_data_out  (local_data_out),
        .local_valid_out (local_valid_out),
        .up_data_in      (up_data_in),
        .up_valid_in     (up_valid_in),
        .up_ready_out    (up_ready_out),
        .up_data_out     (up_data_out),
        .up_valid_out    (up_valid_out),
        .up_ready_in     (up_ready_in),
        .drop_count      (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference routing: where a flit from a given source should end up.
    task automatic push_exp(input logic [15:0] d, input bit from_up);
        if (d[15:10] == 6'd0) exp_drops++;
        else if (d[15:12] == 4'd5) exp_q[d[11:10]].push_back(d);
        else if (from_up) exp_drops++;
        else exp_q[4].push_back(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_local(input int i, input logic [15:0] d);
        local_data_in[i*16 +: 16] = d;
        local_valid_in[i] = 1'b1;
        push_exp(d, 1'b0);
    endtask

    task automatic drive_up(input logic [15:0] d);
        up_data_in  = d;
        up_valid_in = 1'b1;
        push_exp(d, 1'b1);
    endtask

    task automatic idle();
        local_valid_in = 4'd0;
        up_valid_in    = 1'b0;
    endtask

    // Scoreboard monitor: every delivered flit must match the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            for (int o = 0; o < 4; o++) begin
                if (local_valid_out[o]) begin
                    if (exp_q[o].size() == 0)
                        chk($sformatf("spurious_local%0d", o), 32'(local_data_out[o*16 +: 16]), 32'hFFFF_FFFF);
                    else
                        chk($sformatf("local%0d_data", o), 32'(local_data_out[o*16 +: 16]), 32'(exp_q[o].pop_front()));
                end
            end
            if (up_valid_out && up_ready_in) begin
                if (exp_q[4].size() == 0)
                    chk("spurious_up", 32'(up_data_out), 32'hFFFF_FFFF);
                else
                    chk("up_data", 32'(up_data_out), 32'(exp_q[4].pop_front()));
            end
        end
    end

    initial begin
        int sent;
        bit saw_low;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lvalid", 32'(local_valid_out), 32'd0);
        chk("rst_ldata", 32'(local_data_out[31:0] | local_data_out[63:32]), 32'd0);
        chk("rst_uvalid", 32'(up_valid_out), 32'd0);
        chk("rst_udata", 32'(up_data_out), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_lready", 32'(local_ready_out), 32'hF);
        chk("rst_uready", 32'(up_ready_out), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Contention on leaf 2: two bursts, each served 0,1,3,up
        for (int b = 0; b < 2; b++) begin
            drive_local(0, 16'h5A01 + 16'(b * 16));
            drive_local(1, 16'h5A02 + 16'(b * 16));
            drive_local(3, 16'h5A03 + 16'(b * 16));
            drive_up(16'h5B04 + 16'(b * 16));
            tick();
            idle();
            @(negedge clk);
            chk("cont_pre", 32'(local_valid_out[2]), 32'd0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("cont_b%0d_c%0d", b, k), 32'(local_valid_out[2]), 32'd1);
            end
            @(negedge clk);
            chk("cont_post", 32'(local_valid_out[2]), 32'd0);
            tick();
        end

        // Local-to-local latency: NI0 to leaf 2 in exactly two cycles
        drive_local(0, 16'h5A0F);
        tick();
        idle();
        @(negedge clk);
        chk("lat_t1", 32'(local_valid_out), 32'd0);
        @(negedge clk);
        chk("lat_t2", 32'(local_valid_out), 32'b0100);
        chk("lat_t2_up", 32'(up_valid_out), 32'd0);
        tick();

        // Uplink egress with a three-cycle stall
        up_ready_in = 1'b0;
        drive_local(1, 16'h8C01);
        tick();
        idle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(up_valid_out), 32'd1);
            chk("stall_data", 32'(up_data_out), 32'h8C01);
        end
        tick();
        up_ready_in = 1'b1;
        tick();
        chk("stall_clear", 32'(up_valid_out), 32'd0);

        // Backpressure: six uplink flits from NI0 with a stalled uplink
        up_ready_in = 1'b0;
        sent = 0;
        saw_low = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (sent < 6 && local_ready_out[0]) begin
                drive_local(0, 16'h8100 + 16'(sent));
                sent++;
            end else begin
                idle();
                if (!local_ready_out[0]) saw_low = 1'b1;
            end
            tick();
        end
        idle();
        chk("bp_sent_stalled", 32'(sent), 32'd4);
        chk("bp_ready_low", 32'(saw_low), 32'd1);
        chk("bp_ready_now", 32'(local_ready_out[0]), 32'd0);
        up_ready_in = 1'b1;
        for (int k = 0; k < 20 && sent < 6; k++) begin
            if (local_ready_out[0]) begin
                drive_local(0, 16'h8100 + 16'(sent));
                sent++;
            end else begin
                idle();
            end
            tick();
        end
        idle();
        chk("bp_sent_all", 32'(sent), 32'd6);
        repeat (15) tick();
        chk("bp_drained", 32'(exp_q[4].size()), 32'd0);
        chk("bp_drops", 32'(drop_count), 32'(exp_drops));

        // Drops: uplink flit for another group, then a null header
        drive_up(16'h2000);
        tick();
        idle();
        tick();
        chk("drop_up", 32'(drop_count), 32'(exp_drops));
        drive_local(2, 16'h0000);
        tick();
        idle();
        repeat (3) tick();
        chk("drop_null", 32'(drop_count), 32'(exp_drops));

        // Async reset while the uplink register is held
        up_ready_in = 1'b0;
        drive_local(1, 16'h9001);
        tick();
        idle();
        for (int k = 0; k < 10 && !up_valid_out; k++) tick();
        chk("ar_held", 32'(up_valid_out), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_uvalid", 32'(up_valid_out), 32'd0);
        chk("ar_udata", 32'(up_data_out), 32'd0);
        chk("ar_lvalid", 32'(local_valid_out), 32'd0);
        chk("ar_ldata", 32'(local_data_out[31:0] | local_data_out[63:32]), 32'd0);
        chk("ar_drops", 32'(drop_count), 32'd0);
        for (int o = 0; o < 5; o++) exp_q[o].delete();
        exp_drops = 0;
        @(negedge clk);
        reset = 1'b1;
        up_ready_in = 1'b1;
        tick();
        drive_local(3, 16'h5001);
        tick();
        idle();
        @(negedge clk);
        chk("ar_lat_t1", 32'(local_valid_out), 32'd0);
        @(negedge clk);
        chk("ar_lat_t2", 32'(local_valid_out), 32'b0001);
        repeat (4) tick();

        for (int o = 0; o < 5; o++) chk($sformatf("q%0d_empty", o), 32'(exp_q[o].size()), 32'd0);
        chk("final_drops", 32'(drop_count), 32'(exp_drops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
